wb_arbiter: RTL

Shares the scoreboard's `NR_WB_PORTS` write-back ports among `NR_REQ` functional-unit result sources. Each requester gets a one-entry holding register. Held results are granted to the write-back ports round-robin and driven straight onto the scoreboard's `trans_id`/`wbdata`/`ex`/`wt_valid` inputs. Sits between the execute-stage functional units and the scoreboard write-back interface; `flush_i` is tied to the scoreboard flush.

---
 rtl/wb_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares NR_WB_PORTS scoreboard write-back ports among NR_REQ
// functional-unit result sources, one holding register per requester.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   flush_i              drops held and incoming results, masks wt_valid_o
//   req_valid_i/ready_o  per-requester result handshake
//   req_trans_id_i, req_data_i, req_ex_i   per-requester result payload
//   wt_valid_o, trans_id_o, wbdata_o, ex_o per-port write-back outputs

package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

endpackage

module wb_arbiter
    import ariane_pkg::*;
#(
    parameter int NR_REQ      = 4,
    parameter int NR_WB_PORTS = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [NR_REQ-1:0]                         req_valid_i,
    output logic [NR_REQ-1:0]                         req_ready_o,
    input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]      req_trans_id_i,
    input  logic [NR_REQ-1:0][63:0]                   req_data_i,
    input  exception_t [NR_REQ-1:0]                   req_ex_i,
    output logic [NR_WB_PORTS-1:0]                    wt_valid_o,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_o,
    output logic [NR_WB_PORTS-1:0][63:0]              wbdata_o,
    output exception_t [NR_WB_PORTS-1:0]              ex_o
);

    localparam int RR_W = $clog2(NR_REQ);
    localparam int PC_W = $clog2(NR_WB_PORTS + 1);

    // holding registers
    logic [NR_REQ-1:0]                    held_q, held_d;
    logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] tid_q, tid_d;
    logic [NR_REQ-1:0][63:0]              data_q, data_d;
    exception_t [NR_REQ-1:0]              ex_q, ex_d;
    logic [RR_W-1:0]                      rr_q, rr_d;

    // arbitration results
    logic [NR_REQ-1:0]      grant;
    logic [NR_REQ-1:0]      hs;
    logic [NR_WB_PORTS-1:0] port_vld;
    logic                   any_grant;
    logic [RR_W-1:0]        last_idx;
    logic [RR_W:0]          scan_sum;
    logic [RR_W-1:0]        scan_idx;
    logic [PC_W-1:0]        n_used;
    logic                   dup_tid;

    // Scan held entries from rr_q with wrap; the k-th hit takes port k.
    always_comb begin
        grant      = '0;
        port_vld   = '0;
        trans_id_o = '0;
        wbdata_o   = '0;
        ex_o       = '0;
        any_grant  = 1'b0;
        last_idx   = '0;
        n_used     = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (RR_W+1)'(k);
            if (scan_sum >= (RR_W+1)'(NR_REQ)) begin
                scan_sum = scan_sum - (RR_W+1)'(NR_REQ);
            end
            scan_idx = scan_sum[RR_W-1:0];
            if (held_q[scan_idx] && (n_used < PC_W'(NR_WB_PORTS))) begin
                grant[scan_idx] = 1'b1;
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (n_used == PC_W'(p)) begin
                        port_vld[p]   = 1'b1;
                        trans_id_o[p] = tid_q[scan_idx];
                        wbdata_o[p]   = data_q[scan_idx];
                        ex_o[p]       = ex_q[scan_idx];
                    end
                end
                last_idx  = scan_idx;
                any_grant = 1'b1;
                n_used    = n_used + 1'b1;
            end
        end
    end

    // Ready comes from registered state only; flush does not gate it.
    assign req_ready_o = ~held_q | grant;
    assign hs          = req_valid_i & req_ready_o;
    assign wt_valid_o  = flush_i ? '0 : port_vld;

    // Next state: a handshake reloads, otherwise a grant clears.
    always_comb begin
        held_d = held_q;
        tid_d  = tid_q;
        data_d = data_q;
        ex_d   = ex_q;
        rr_d   = rr_q;
        for (int i = 0; i < NR_REQ; i++) begin
            if (hs[i]) begin
                held_d[i] = 1'b1;
                tid_d[i]  = req_trans_id_i[i];
                data_d[i] = req_data_i[i];
                ex_d[i]   = req_ex_i[i];
            end else if (grant[i]) begin
                held_d[i] = 1'b0;
            end
        end
        if (any_grant) begin
            if (last_idx == RR_W'(NR_REQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = last_idx + 1'b1;
            end
        end
        if (flush_i) begin
            held_d = '0;
            rr_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            held_q <= '0;
            tid_q  <= '0;
            data_q <= '0;
            ex_q   <= '0;
            rr_q   <= '0;
        end else begin
            held_q <= held_d;
            tid_q  <= tid_d;
            data_q <= data_d;
            ex_q   <= ex_d;
            rr_q   <= rr_d;
        end
    end

    // Two held results sharing a trans_id would corrupt the scoreboard.
    always_comb begin
        dup_tid = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            for (int j = i + 1; j < NR_REQ; j++) begin
                if (held_q[i] && held_q[j] && (tid_q[i] == tid_q[j])) begin
                    dup_tid = 1'b1;
                end
            end
        end
    end

    a_no_dup_tid : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !dup_tid
    );

endmodule
